chargen_fetch_ctrl: RTL and testbench

CHARGEN_FETCH_CTRL -- requirements
Module: chargen_fetch_ctrl

---
 rtl/chargen_fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_chargen_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chargen_fetch_ctrl.sv
// chargen_fetch_ctrl
//   Text-mode character generator fetch controller. For each scanline it
//   walks columns 0..COLS-1. Each column takes three steps:
//     1. Read the character code from VRAM.
//     2. Look up the glyph row in the character ROM.
//     3. Push the pixel byte into a 2-entry first-word-fall-through FIFO.
//
// Optional feature (compile-time macro CHARGEN_INVERSE_EN):
//   - vram_data[7] becomes a per-character inverse-video flag.
//   - Only the low 7 code bits address the ROM.
//   - The pixel byte is complemented when the flag is set.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   line_start              : one-cycle request to fetch a scanline
//   text_row[4:0]           : text row, latched on an accepted line_start
//   font_row[2:0]           : glyph row, latched on an accepted line_start
//   busy                    : line in progress (until the last push)
//   vram_req/vram_gnt       : VRAM read handshake
//   vram_addr[10:0]         : {text_row, col}
//   vram_data[7:0]          : character code, valid the cycle after the grant
//   rom_ce/rom_oce          : character ROM clock/output enables
//   rom_ad[11:0]            : character ROM address
//   rom_dout[7:0]           : ROM data (one-cycle latency)
//   out_valid/out_ready     : output stream handshake
//   out_data[7:0]           : glyph pixels
//   out_last                : marks column COLS-1
module chargen_fetch_ctrl #(
  parameter int COLS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        line_start,
  input  logic [4:0]  text_row,
  input  logic [2:0]  font_row,
  output logic        busy,
  output logic        vram_req,
  input  logic        vram_gnt,
  output logic [10:0] vram_addr,
  input  logic [7:0]  vram_data,
  output logic        rom_ce,
  output logic        rom_oce,
  output logic [11:0] rom_ad,
  input  logic [7:0]  rom_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);

  typedef enum logic [1:0] {IDLE, REQ, VDATA, RDATA} state_t;

  state_t      state, state_nxt;
  logic [5:0]  col;
  logic [4:0]  row_r;
  logic [2:0]  font_r;

  logic [7:0]  fifo_data [2];
  logic        fifo_last [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        push, pop;
  logic [7:0]  push_data;

`ifdef CHARGEN_INVERSE_EN
  logic        inv_r;

  function automatic logic [7:0] apply_inverse(input logic [7:0] d, input logic inv);
    return inv ? ~d : d;
  endfunction

  assign push_data = apply_inverse(rom_dout, inv_r);
`else
  assign push_data = rom_dout;
`endif

  assign busy      = (state != IDLE);
  assign vram_addr = {row_r, col};
  assign pop       = (count != 2'd0) && out_ready;
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : 8'd0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  // Next-state and per-state outputs
  always_comb begin
    state_nxt = state;
    vram_req  = 1'b0;
    rom_ce    = 1'b0;
    rom_oce   = 1'b0;
    rom_ad    = 12'd0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (line_start) state_nxt = REQ;
      end
      REQ: begin
        // Only issue when the FIFO can take the result; with a single
        // character in flight this alone prevents overflow.
        if (count < 2'd2) begin
          vram_req = 1'b1;
          if (vram_gnt) state_nxt = VDATA;
        end
      end
      VDATA: begin
        rom_ce = 1'b1;
`ifdef CHARGEN_INVERSE_EN
        rom_ad = {2'b00, vram_data[6:0], font_r};
`else
        rom_ad = {1'b0, vram_data, font_r};
`endif
        state_nxt = RDATA;
      end
      RDATA: begin
        rom_oce = 1'b1;
        push    = 1'b1;
        state_nxt = (col == LAST_COL) ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, column counter, FIFO pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      col    <= 6'd0;
      row_r  <= 5'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && line_start) begin
        col   <= 6'd0;
        row_r <= text_row;
      end else if (state == RDATA && col != LAST_COL) begin
        col <= col + 6'd1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data registers: no reset needed, qualified by control state
  always_ff @(posedge clk) begin
    if (state == IDLE && line_start) font_r <= font_row;
`ifdef CHARGEN_INVERSE_EN
    if (state == VDATA) inv_r <= vram_data[7];
`endif
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_last[wr_ptr] <= (col == LAST_COL);
    end
  end

endmodule

// File: tb/tb_chargen_fetch_ctrl.sv
module tb_chargen_fetch_ctrl;
  localparam int COLS = 4;

  logic        clk = 1'b0;
  logic        rst_n, line_start, vram_gnt, out_ready;
  logic [4:0]  text_row;
  logic [2:0]  font_row;
  logic        busy, vram_req, rom_ce, rom_oce, out_valid, out_last;
  logic [10:0] vram_addr;
  logic [7:0]  vram_data, rom_dout, out_data;
  logic [11:0] rom_ad;

  always #5 clk = ~clk;

  chargen_fetch_ctrl #(.COLS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .line_start(line_start), .text_row(text_row),
    .font_row(font_row), .busy(busy), .vram_req(vram_req), .vram_gnt(vram_gnt),
    .vram_addr(vram_addr), .vram_data(vram_data), .rom_ce(rom_ce),
    .rom_oce(rom_oce), .rom_ad(rom_ad), .rom_dout(rom_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  // VRAM and ROM models
  logic [7:0] vram_mem [64];
  logic       rom_force;
  always @(posedge clk) begin
    if (vram_req && vram_gnt) vram_data <= vram_mem[vram_addr[5:0]];
    if (rom_ce) rom_dout <= rom_force ? 8'h3C : (rom_ad[10:3] ^ {rom_ad[2:0], 5'b0});
  end

  typedef struct {
    logic [7:0]  code;
    logic [10:0] addr;
    logic [11:0] rad;
    logic [7:0]  dout;
    logic        last;
  } vec_t;
  vec_t cur [COLS];

  int pass_cnt = 0;
  int total = 0;
  logic [31:0] addr_q[$], rad_q[$], out_q[$];
  int busy_cyc, ce_cnt, oce_cnt, req_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic clear_logs();
    addr_q.delete(); rad_q.delete(); out_q.delete();
    busy_cyc = 0; ce_cnt = 0; oce_cnt = 0; req_cyc = 0;
  endtask

  // One clock: log at the falling edge, return 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (vram_req && vram_gnt) addr_q.push_back(32'(vram_addr));
    if (rom_ce) rad_q.push_back(32'(rom_ad));
    if (out_valid && out_ready) out_q.push_back(32'({out_last, out_data}));
    if (busy) busy_cyc++;
    if (rom_ce) ce_cnt++;
    if (rom_oce) oce_cnt++;
    if (vram_req) req_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [4:0] row, input logic [2:0] frow);
    text_row = row; font_row = frow; line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((busy || out_valid) && n < 200) begin tick(); n++; end
    if (busy || out_valid) begin
      total++;
      $display("FAIL wait_done: timeout busy=%0b out_valid=%0b", busy, out_valid);
    end
  endtask

  task automatic load_vram();
    for (int i = 0; i < COLS; i++) vram_mem[i] = cur[i].code;
  endtask

  task automatic check_line(input string tag);
    chk({tag, " n_addr"}, 32'(addr_q.size()), 32'(COLS));
    chk({tag, " n_rad"},  32'(rad_q.size()),  32'(COLS));
    chk({tag, " n_out"},  32'(out_q.size()),  32'(COLS));
    for (int i = 0; i < COLS; i++) begin
      if (i < addr_q.size()) chk($sformatf("%s addr%0d", tag, i), addr_q[i], 32'(cur[i].addr));
      if (i < rad_q.size())  chk($sformatf("%s rad%0d", tag, i), rad_q[i], 32'(cur[i].rad));
      if (i < out_q.size())  chk($sformatf("%s out%0d", tag, i), out_q[i], 32'({cur[i].last, cur[i].dout}));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"},      32'(busy),      0);
    chk({tag, " vram_req"},  32'(vram_req),  0);
    chk({tag, " rom_ce"},    32'(rom_ce),    0);
    chk({tag, " rom_oce"},   32'(rom_oce),   0);
    chk({tag, " out_valid"}, 32'(out_valid), 0);
    chk({tag, " out_last"},  32'(out_last),  0);
    chk({tag, " vram_addr"}, 32'(vram_addr), 0);
    chk({tag, " rom_ad"},    32'(rom_ad),    0);
    chk({tag, " out_data"},  32'(out_data),  0);
  endtask

  task automatic set_basic();
    cur[0] = '{8'h41, 11'h0C0, 12'h20D, 8'hE1, 1'b0};
    cur[1] = '{8'h42, 11'h0C1, 12'h215, 8'hE2, 1'b0};
    cur[2] = '{8'h43, 11'h0C2, 12'h21D, 8'hE3, 1'b0};
    cur[3] = '{8'h44, 11'h0C3, 12'h225, 8'hE4, 1'b1};
  endtask

  initial begin
    logic [31:0] tmp;
    rst_n = 1'b0; line_start = 1'b0; text_row = '0; font_row = '0;
    vram_gnt = 1'b1; out_ready = 1'b1; rom_force = 1'b0;
    for (int i = 0; i < 64; i++) vram_mem[i] = 8'h00;
    clear_logs();

    // Reset state
    tick(); tick();
    check_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // Basic line: row 3, font 5, codes 0x41..0x44
    set_basic(); load_vram(); clear_logs();
    pulse_start(5'd3, 3'd5);
    wait_done();
    check_line("basic");
    chk("basic busy_cycles", 32'(busy_cyc), 32'd12);
    chk("basic rom_ce_pulses", 32'(ce_cnt), 32'd4);
    chk("basic rom_oce_pulses", 32'(oce_cnt), 32'd4);

    // Backpressure: row 1, font 2, codes 0x10..0x13
    cur[0] = '{8'h10, 11'h040, 12'h082, 8'h50, 1'b0};
    cur[1] = '{8'h11, 11'h041, 12'h08A, 8'h51, 1'b0};
    cur[2] = '{8'h12, 11'h042, 12'h092, 8'h52, 1'b0};
    cur[3] = '{8'h13, 11'h043, 12'h09A, 8'h53, 1'b1};
    load_vram(); clear_logs();
    out_ready = 1'b0;
    pulse_start(5'd1, 3'd2);
    for (int i = 0; i < 20; i++) tick();
    chk("bp pushes", 32'(oce_cnt), 32'd2);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp head_data", 32'(out_data), 32'h50);
    chk("bp busy", 32'(busy), 32'd1);
    req_cyc = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp vram_req_cycles", 32'(req_cyc), 32'd0);
    out_ready = 1'b1;
    wait_done();
    check_line("bp");

    // Grant stall: row 7, font 0, codes 0x20..0x23
    cur[0] = '{8'h20, 11'h1C0, 12'h100, 8'h20, 1'b0};
    cur[1] = '{8'h21, 11'h1C1, 12'h108, 8'h21, 1'b0};
    cur[2] = '{8'h22, 11'h1C2, 12'h110, 8'h22, 1'b0};
    cur[3] = '{8'h23, 11'h1C3, 12'h118, 8'h23, 1'b1};
    load_vram(); clear_logs();
    vram_gnt = 1'b0;
    pulse_start(5'd7, 3'd0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall vram_req%0d", i), 32'(vram_req), 32'd1);
      chk($sformatf("stall vram_addr%0d", i), 32'(vram_addr), 32'h1C0);
      tick();
    end
    chk("stall rom_ce_pulses", 32'(ce_cnt), 32'd0);
    vram_gnt = 1'b1;
    wait_done();
    check_line("stall");

    // line_start while busy: row 2, font 1, codes 0x30..0x33
    cur[0] = '{8'h30, 11'h080, 12'h181, 8'h10, 1'b0};
    cur[1] = '{8'h31, 11'h081, 12'h189, 8'h11, 1'b0};
    cur[2] = '{8'h32, 11'h082, 12'h191, 8'h12, 1'b0};
    cur[3] = '{8'h33, 11'h083, 12'h199, 8'h13, 1'b1};
    load_vram(); clear_logs();
    pulse_start(5'd2, 3'd1);
    for (int i = 0; i < 4; i++) tick();
    pulse_start(5'd9, 3'd6);
    wait_done();
    check_line("ignore");
    for (int i = 0; i < 10; i++) tick();
    chk("ignore no_extra_out", 32'(out_q.size()), 32'(COLS));
    chk("ignore idle_busy", 32'(busy), 32'd0);

    // Reset mid-line with buffered data
    set_basic(); load_vram(); clear_logs();
    out_ready = 1'b0;
    pulse_start(5'd3, 3'd5);
    for (int i = 0; i < 8; i++) tick();
    chk("midrst pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    check_all_zero("midrst");
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    clear_logs();
    for (int i = 0; i < 15; i++) tick();
    chk("midrst stale_out", 32'(out_q.size()), 32'd0);
    chk("midrst busy_cycles", 32'(busy_cyc), 32'd0);
    clear_logs();
    pulse_start(5'd3, 3'd5);
    wait_done();
    check_line("recover");

    // Inverse flag handling, forced ROM data 0x3C
    vram_mem[0] = 8'hC1; vram_mem[1] = 8'h01; vram_mem[2] = 8'h81; vram_mem[3] = 8'h02;
    rom_force = 1'b1;
    clear_logs();
    pulse_start(5'd0, 3'd3);
    wait_done();
    chk("inv n_out", 32'(out_q.size()), 32'(COLS));
    if (rad_q.size() > 0) begin
      tmp = rad_q[0];
`ifdef CHARGEN_INVERSE_EN
      chk("inv rom_ad_code", 32'(tmp[10:3]), 32'h41);
`else
      chk("inv rom_ad_code", 32'(tmp[10:3]), 32'hC1);
`endif
    end
    if (out_q.size() > 1) begin
`ifdef CHARGEN_INVERSE_EN
      chk("inv out0", out_q[0], 32'h0C3);
`else
      chk("inv out0", out_q[0], 32'h03C);
`endif
      chk("inv out1", out_q[1], 32'h03C);
    end
    rom_force = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
